johnson_counter_param: RTL and testbench

Parametrised Johnson (twisted-ring) counter for sequencing and phase generation. It supports a configurable width, enable, up/down direction, synchronous clear and parallel load. It detects and self-corrects illegal codes, and provides a binary phase index, a wrap pulse and an error pulse. It serves as the generic phase sequencer for timing and control blocks.

---
 rtl/johnson_pkg.sv | 33 +++
 rtl/jc_decode.sv | 30 +++
 rtl/johnson_counter_param.sv | 79 +++++++
 tb/tb_johnson_counter_param.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared helpers for the Johnson (twisted-ring) counter.
//   jc_valid : 1 when a code of the given width is a legal Johnson state
//   jc_next  : one step forward (dir=0) or reverse (dir=1)
//   JC_ZERO  : the all-zeros state
// Codes are carried in a 32-bit container (the maximum ring length). The
// live width is passed in, and bits above that width are ignored or cleared.
package johnson_pkg;

  localparam int JC_MAX_W = 32;
  localparam logic [JC_MAX_W-1:0] JC_ZERO = '0;

  // A legal code is either ones packed from the MSB or ones packed from the
  // LSB. In both shapes the bit string changes value at most once.
  function automatic logic jc_valid(input logic [JC_MAX_W-1:0] code, input int w);
    int edges;
    edges = 0;
    for (int i = 0; i < JC_MAX_W - 1; i++)
      if (i < w - 1 && code[i] != code[i+1]) edges++;
    return (edges <= 1);
  endfunction

  // Forward: {~c[0], c[w-1:1]}. Reverse: {c[w-2:0], ~c[w-1]}.
  function automatic logic [JC_MAX_W-1:0] jc_next(input logic [JC_MAX_W-1:0] code,
                                                  input logic dir, input int w);
    logic [JC_MAX_W-1:0] mask;
    logic [JC_MAX_W-1:0] nxt;
    mask = (w >= JC_MAX_W) ? '1 : ((32'd1 << w) - 32'd1);
    if (!dir) nxt = (code >> 1) | ({31'd0, ~code[0]} << (w - 1));
    else      nxt = (code << 1) | {31'd0, ~code[w-1]};
    return nxt & mask;
  endfunction

endpackage

// File: rtl/jc_decode.sv
// Combinational Johnson-code decoder.
//   code  : WIDTH-bit code under test
//   valid : code is one of the 2*WIDTH legal states
//   phase : binary index of code in the sequence (0 for an illegal code)
module jc_decode
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int PH_W  = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             valid,
  output logic [PH_W-1:0]  phase
);

  int ones;

  always_comb begin
    valid = jc_valid(32'(code), WIDTH);
    ones  = $countones(code);
    phase = '0;
    // An MSB-packed code sits at index k = popcount. An LSB-packed code with
    // j ones sits at 2*WIDTH - j. A zero code and an illegal code both read 0.
    if (valid && code != '0) begin
      if (code[WIDTH-1]) phase = PH_W'(ones);
      else               phase = PH_W'(2 * WIDTH - ones);
    end
  end

endmodule

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson counter with up/down stepping, clear and load.
// Illegal codes are corrected to all-zeros, and the correction raises err.
//   clk, n_rst     : clock, asynchronous active-low reset
//   en, dir        : step enable, direction (0 forward, 1 reverse)
//   clr, load      : synchronous clear / parallel load (clr > load > en)
//   load_val       : value to load; an illegal value loads zero and flags err
//   cnt, phase     : registered state, combinational phase index
//   wrap, err      : registered one-cycle pulses
module johnson_counter_param
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int PH_W  = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic [PH_W-1:0]  phase,
  output logic             wrap,
  output logic             err
);

  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_step;
  logic             wrap_q, wrap_d, err_q, err_d;
  logic             cnt_valid, ld_valid;
  logic [PH_W-1:0]  ld_phase_unused;

  jc_decode #(.WIDTH(WIDTH)) u_cnt_dec (.code(cnt_q),    .valid(cnt_valid), .phase(phase));
  jc_decode #(.WIDTH(WIDTH)) u_ld_dec  (.code(load_val), .valid(ld_valid),  .phase(ld_phase_unused));

  assign cnt_step = WIDTH'(jc_next(32'(cnt_q), dir, WIDTH));

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      if (ld_valid) cnt_d = load_val;
      else begin
        cnt_d = '0;
        err_d = 1'b1;
      end
    end else if (en) begin
      if (cnt_valid) begin
        cnt_d  = cnt_step;
        // Only a counting step from a nonzero legal state into zero is a
        // wrap. That is 0..01 forward or 10..0 reverse.
        wrap_d = (cnt_q != JC_ZERO[WIDTH-1:0]) && (cnt_step == '0);
      end else begin
        cnt_d = '0;
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_johnson_counter_param.sv
module tb_johnson_counter_param;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       en, dir, clr, load, en_b;
  logic [3:0] load_val;
  logic [3:0] cnt;
  logic [2:0] phase;
  logic       wrap, err;
  logic [4:0] cnt_b;
  logic [3:0] phase_b;
  logic       wrap_b, err_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          b5;
    logic [31:0] cnt;
    logic [31:0] ph;
    logic        wrap;
    logic        err;
    string       tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  johnson_counter_param #(.WIDTH(4)) dut (
    .clk(clk), .n_rst(n_rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt), .phase(phase), .wrap(wrap), .err(err));

  johnson_counter_param #(.WIDTH(5)) dut5 (
    .clk(clk), .n_rst(n_rst), .en(en_b), .dir(dir), .clr(1'b0), .load(1'b0),
    .load_val(5'd0), .cnt(cnt_b), .phase(phase_b), .wrap(wrap_b), .err(err_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (e.b5) begin
      chk({e.tag, ".cnt"},   32'(cnt_b),   e.cnt);
      chk({e.tag, ".phase"}, 32'(phase_b), e.ph);
      chk({e.tag, ".wrap"},  32'(wrap_b),  32'(e.wrap));
      chk({e.tag, ".err"},   32'(err_b),   32'(e.err));
    end else begin
      chk({e.tag, ".cnt"},   32'(cnt),   e.cnt);
      chk({e.tag, ".phase"}, 32'(phase), e.ph);
      chk({e.tag, ".wrap"},  32'(wrap),  32'(e.wrap));
      chk({e.tag, ".err"},   32'(err),   32'(e.err));
    end
  endtask

  // One clock on the WIDTH=4 counter: drive at negedge, queue expectation,
  // compare just after the rising edge.
  task automatic step4(input string tag, input logic e, d, c, l, input logic [3:0] lv,
                       input logic [3:0] ecnt, input int eph, input logic ew, ee);
    exp_t x;
    @(negedge clk);
    en = e; dir = d; clr = c; load = l; load_val = lv; en_b = 1'b0;
    x.b5 = 1'b0; x.cnt = 32'(ecnt); x.ph = 32'(eph); x.wrap = ew; x.err = ee; x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1 pop_check();
  endtask

  // Independent reference for WIDTH=5: code for a given phase index.
  function automatic logic [4:0] code5(input int p);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 5; i++) begin
      if (p <= 5) c[i] = (i >= 5 - p);
      else        c[i] = (i < 10 - p);
    end
    return c;
  endfunction

  initial begin
    int   p5;
    exp_t x;
    n_rst = 1'b0; en = 0; dir = 0; clr = 0; load = 0; load_val = '0; en_b = 0;
    #2;
    chk("rst.cnt", 32'(cnt), 0);     chk("rst.phase", 32'(phase), 0);
    chk("rst.wrap", 32'(wrap), 0);   chk("rst.err", 32'(err), 0);
    chk("rst.cnt5", 32'(cnt_b), 0);
    @(negedge clk); n_rst = 1'b1;

    // 1: forward sweep
    step4("fwd1", 1,0,0,0,4'h0, 4'b1000, 1, 0, 0);
    step4("fwd2", 1,0,0,0,4'h0, 4'b1100, 2, 0, 0);
    step4("fwd3", 1,0,0,0,4'h0, 4'b1110, 3, 0, 0);
    step4("fwd4", 1,0,0,0,4'h0, 4'b1111, 4, 0, 0);
    step4("fwd5", 1,0,0,0,4'h0, 4'b0111, 5, 0, 0);
    step4("fwd6", 1,0,0,0,4'h0, 4'b0011, 6, 0, 0);
    step4("fwd7", 1,0,0,0,4'h0, 4'b0001, 7, 0, 0);
    step4("fwd8", 1,0,0,0,4'h0, 4'b0000, 0, 1, 0);
    step4("fwd9", 1,0,0,0,4'h0, 4'b1000, 1, 0, 0);

    // 2: load then reverse to wrap
    step4("ld1110", 0,0,0,1,4'b1110, 4'b1110, 3, 0, 0);
    step4("rev1",   1,1,0,0,4'h0,    4'b1100, 2, 0, 0);
    step4("rev2",   1,1,0,0,4'h0,    4'b1000, 1, 0, 0);
    step4("rev3",   1,1,0,0,4'h0,    4'b0000, 0, 1, 0);
    step4("rev4",   1,1,0,0,4'h0,    4'b0001, 7, 0, 0);

    // 3: illegal load, then legal load, then hold
    step4("ldbad",  0,0,0,1,4'b1010, 4'b0000, 0, 0, 1);
    step4("ld0011", 0,0,0,1,4'b0011, 4'b0011, 6, 0, 0);
    step4("hold",   0,0,0,0,4'b1111, 4'b0011, 6, 0, 0);

    // 4: upset register, then correction on the next step
    @(negedge clk);
    force dut.cnt_q = 4'b0101;
    #1 release dut.cnt_q;
    #1;
    chk("upset.cnt", 32'(cnt), 32'h5);
    chk("upset.phase", 32'(phase), 0);
    step4("fix",   1,0,0,0,4'h0, 4'b0000, 0, 0, 1);
    step4("fix+1", 1,0,0,0,4'h0, 4'b1000, 1, 0, 0);

    // 5: priority
    step4("clrwin", 1,0,1,1,4'b1111, 4'b0000, 0, 0, 0);
    step4("ldwin",  1,0,0,1,4'b0111, 4'b0111, 5, 0, 0);

    // 6: async reset mid-count
    step4("ld1100", 0,0,0,1,4'b1100, 4'b1100, 2, 0, 0);
    step4("to1110", 1,0,0,0,4'h0,    4'b1110, 3, 0, 0);
    #2 n_rst = 1'b0;
    #1;
    chk("arst.cnt", 32'(cnt), 0);  chk("arst.phase", 32'(phase), 0);
    chk("arst.wrap", 32'(wrap), 0); chk("arst.err", 32'(err), 0);
    @(negedge clk); en = 0; n_rst = 1'b1;
    step4("restart", 1,0,0,0,4'h0, 4'b1000, 1, 0, 0);

    // WIDTH=5 forward run: wrap every 10 steps
    p5 = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      en = 0; clr = 0; load = 0; dir = 0; en_b = 1;
      p5 = (p5 + 1) % 10;
      x.b5 = 1'b1; x.cnt = 32'(code5(p5)); x.ph = 32'(p5);
      x.wrap = (p5 == 0); x.err = 1'b0; x.tag = $sformatf("w5_%0d", i);
      sb.push_back(x);
      @(posedge clk);
      #1 pop_check();
    end

    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
